fsm_protocolo_tx: RTL

//  Initiator (transmit end) of the 2-bit E/Y handshake protocol.

---
 rtl/fsm_protocolo_tx_pkg.sv | 41 ++++
 rtl/fsm_protocolo_tx_if.sv | 34 +++
 rtl/fsm_protocolo_tx_fifo.sv | 52 +++++
 rtl/fsm_protocolo_tx.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fsm_protocolo_tx_pkg.sv
// Shared types and link symbols for the E/Y handshake protocol.
// Both ends of the link import this package so symbol values and state
// encodings stay in one place.
package protocolo_pkg;

    // Two-bit link symbols carried on E and echoed on Y
    localparam logic [1:0] SYM_IDLE  = 2'b00;
    localparam logic [1:0] SYM_START = 2'b01;
    localparam logic [1:0] SYM_D0    = 2'b10;
    localparam logic [1:0] SYM_D1    = 2'b11;

    // Initiator states; any other encoding is treated as T_IDLE
    typedef enum logic [2:0] {
        T_IDLE,
        T_START,
        T_HOLD,
        T_DATA,
        T_ACK,
        T_DRAIN
    } tx_state_t;

    // Responder states, kept here so both link ends share one package
    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_ACK
    } rx_state_t;

    // One queued request: data symbol plus extra START wait cycles
    typedef struct packed {
        logic       data_bit;
        logic [1:0] hold;
    } tx_req_t;

    // Data symbol for a given bit value
    function automatic logic [1:0] data_sym(input logic b);
        return b ? SYM_D1 : SYM_D0;
    endfunction

endpackage

// File: rtl/fsm_protocolo_tx_if.sv
// Request, link and status bundle of the protocol initiator.
// master = the initiator itself, slave = whoever drives requests and Y.
interface fsm_protocolo_tx_if #(
    parameter int CNT_W = 8
);
    import protocolo_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic             req_bit;
    logic [1:0]       req_hold;
    logic [1:0]       E;
    logic [1:0]       Y;
    logic             done_valid;
    logic             done_err;
    logic             done_bit;
    logic             busy;
    logic [CNT_W-1:0] ok_count;
    logic [CNT_W-1:0] err_count;
    tx_state_t        tx_state;

    modport master (
        input  req_valid, req_bit, req_hold, Y,
        output req_ready, E, done_valid, done_err, done_bit, busy,
               ok_count, err_count, tx_state
    );

    modport slave (
        output req_valid, req_bit, req_hold, Y,
        input  req_ready, E, done_valid, done_err, done_bit, busy,
               ok_count, err_count, tx_state
    );

endinterface

// File: rtl/fsm_protocolo_tx_fifo.sv
// Request queue of the protocol initiator: plain synchronous FIFO.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// The read side shows the head entry combinationally; a pushed entry only
// becomes visible after the clock edge that writes it, so there is no bypass.
module protocolo_tx_fifo
    import protocolo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  tx_req_t push_data,
    input  logic    pop,
    output tx_req_t pop_data,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    tx_req_t       mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Advance the write/read pointers on accepted push/pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage array; contents need no reset because empty guards the reads
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/fsm_protocolo_tx.sv
// Initiator end of the E/Y handshake link. Queues 1-bit requests and sends
// each as START, optional wait states, DATA, IDLE, checking the responder's
// echo every frame cycle. A bad echo drains the link for two cycles and the
// frame is retried up to MAX_RETRY times before it is reported as failed.
module fsm_protocolo_tx
    import protocolo_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_RETRY  = 2,
    parameter int CNT_W      = 8
) (
    input logic clk,
    input logic reset,
    fsm_protocolo_tx_if.master bus
);

    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    tx_state_t          state;
    tx_req_t            cur_req;
    tx_req_t            head;
    logic [1:0]         hold_cnt;
    logic               drain_cnt;
    logic [RETRY_W-1:0] retry_cnt;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               y_ok;
    logic               done_valid_q;
    logic               done_err_q;
    logic               done_bit_q;
    logic [CNT_W-1:0]   ok_cnt_q;
    logic [CNT_W-1:0]   err_cnt_q;

    assign push = bus.req_valid && !fifo_full;

    protocolo_tx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({bus.req_bit, bus.req_hold}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Expected echo for the current state, and whether the FSM takes a new entry now
    always_comb begin
        y_ok = 1'b1;
        case (state)
            T_START:        y_ok = (bus.Y == SYM_IDLE);
            T_HOLD, T_DATA: y_ok = (bus.Y == SYM_START);
            T_ACK:          y_ok = (bus.Y == data_sym(cur_req.data_bit));
            default:        y_ok = 1'b1;
        endcase
        pop = !fifo_empty && ((state == T_IDLE) || ((state == T_ACK) && y_ok));
    end

    // Frame sequencer with its counters, done register and statistics
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= T_IDLE;
            cur_req      <= '0;
            hold_cnt     <= '0;
            drain_cnt    <= 1'b0;
            retry_cnt    <= '0;
            done_valid_q <= 1'b0;
            done_err_q   <= 1'b0;
            done_bit_q   <= 1'b0;
            ok_cnt_q     <= '0;
            err_cnt_q    <= '0;
        end else begin
            done_valid_q <= 1'b0;
            case (state)
                T_IDLE: begin
                    if (pop) begin
                        cur_req  <= head;
                        hold_cnt <= head.hold;
                        state    <= T_START;
                    end
                end
                T_START: begin
                    if (!y_ok) begin
                        drain_cnt <= 1'b0;
                        state     <= T_DRAIN;
                    end else if (hold_cnt == 2'd0) begin
                        state <= T_DATA;
                    end else begin
                        state <= T_HOLD;
                    end
                end
                T_HOLD: begin
                    if (!y_ok) begin
                        drain_cnt <= 1'b0;
                        state     <= T_DRAIN;
                    end else begin
                        hold_cnt <= hold_cnt - 2'd1;
                        if (hold_cnt == 2'd1) begin
                            state <= T_DATA;
                        end
                    end
                end
                T_DATA: begin
                    if (!y_ok) begin
                        drain_cnt <= 1'b0;
                        state     <= T_DRAIN;
                    end else begin
                        state <= T_ACK;
                    end
                end
                T_ACK: begin
                    if (!y_ok) begin
                        drain_cnt <= 1'b0;
                        state     <= T_DRAIN;
                    end else begin
                        done_valid_q <= 1'b1;
                        done_err_q   <= 1'b0;
                        done_bit_q   <= cur_req.data_bit;
                        retry_cnt    <= '0;
                        if (ok_cnt_q != CNT_MAX) begin
                            ok_cnt_q <= ok_cnt_q + CNT_W'(1);
                        end
                        if (pop) begin
                            cur_req  <= head;
                            hold_cnt <= head.hold;
                            state    <= T_START;
                        end else begin
                            state <= T_IDLE;
                        end
                    end
                end
                T_DRAIN: begin
                    if (drain_cnt == 1'b0) begin
                        drain_cnt <= 1'b1;
                    end else if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
                        retry_cnt <= retry_cnt + RETRY_W'(1);
                        hold_cnt  <= cur_req.hold;
                        state     <= T_START;
                    end else begin
                        done_valid_q <= 1'b1;
                        done_err_q   <= 1'b1;
                        done_bit_q   <= cur_req.data_bit;
                        retry_cnt    <= '0;
                        if (err_cnt_q != CNT_MAX) begin
                            err_cnt_q <= err_cnt_q + CNT_W'(1);
                        end
                        state <= T_IDLE;
                    end
                end
                default: begin
                    state <= T_IDLE;
                end
            endcase
        end
    end

    // Link symbol decoded purely from the state register and latched request
    always_comb begin
        bus.E = SYM_IDLE;
        case (state)
            T_START, T_HOLD: bus.E = SYM_START;
            T_DATA:          bus.E = data_sym(cur_req.data_bit);
            default:         bus.E = SYM_IDLE;
        endcase
    end

    assign bus.req_ready  = !fifo_full;
    assign bus.done_valid = done_valid_q;
    assign bus.done_err   = done_err_q;
    assign bus.done_bit   = done_bit_q;
    assign bus.busy       = (state != T_IDLE) || !fifo_empty;
    assign bus.ok_count   = ok_cnt_q;
    assign bus.err_count  = err_cnt_q;
    assign bus.tx_state   = state;

endmodule
